axis_pkt_sink_mem: RTL and testbench

- Parametrised AXI4-Stream slave sink that captures accepted beats into an internal memory with per-byte enables from tkeep/tstrb.
- Tracks packet boundaries, beat counts and packet count, and handles overflow (stall or wrap).
- Provides a registered read-back port so benches and downstream logic can inspect captured data.
- Sits at the end of stream test chains as the generalised successor of the fixed 32-bit/128-word sink.

---
 rtl/axis_pkt_sink_mem_pkg.sv | 25 ++
 rtl/axis_pkt_sink_mem_if.sv | 16 +
 rtl/axis_pkt_sink_mem_bytemem.sv | 44 ++++
 rtl/axis_pkt_sink_mem.sv | 169 ++++++++++++++++
 tb/tb_axis_pkt_sink_mem.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_sink_mem_pkg.sv
// axis_sink_pkg: shared types and constants for the AXI4-Stream packet sink.
//   state_e      - sink FSM states (S_IDLE, S_PKT, S_FULL)
//   OVF_STALL/OVF_WRAP - full-memory policy encodings for OVF_MODE
//   LEN_W        - width of beat/packet counters
//   LFSR_SEED    - seed of the optional flow-simulation LFSR
//   lfsr_next()  - one step of the 6-bit backpressure LFSR
package axis_sink_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  localparam int OVF_STALL = 0;
  localparam int OVF_WRAP  = 1;

  localparam int         LEN_W     = 16;
  localparam logic [5:0] LFSR_SEED = 6'b000101;

  function automatic logic [5:0] lfsr_next(input logic [5:0] s);
    return {s[4:0], ~(s[5] ^ s[4])};
  endfunction

endpackage

// File: rtl/axis_pkt_sink_mem_if.sv
// axis_pkt_sink_mem_if: AXI4-Stream beat bundle.
//   tdata/tstrb/tkeep/tlast/tvalid - driven by the master
//   tready                         - driven by the slave (sink)
interface axis_pkt_sink_mem_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tstrb, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_sink_mem_bytemem.sv
// axis_sink_bytemem: DEPTH x DATA_W storage with per-byte write enables and a
// registered read port. A read of the word written in the same cycle returns
// the previous contents (read-first).
//   clk_i, rst_i    - clock, synchronous active-high reset (read register only)
//   we_i, be_i      - write strobe and per-byte enables
//   wr_addr_i/wr_data_i - write address and data
//   rd_addr_i       - read address, sampled every cycle
//   rd_data_o       - read data, one cycle after rd_addr_i
module axis_sink_bytemem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [NB-1:0]     be_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_pkt_sink_mem.sv
// axis_pkt_sink_mem: AXI4-Stream sink capturing accepted beats into memory.
// Byte lane i is written only when tkeep[i] & tstrb[i]; fully masked beats
// still count and advance the pointer.
// Build option: define AXIS_SINK_FLOW_SIM_EN to throttle tready with a 6-bit
// LFSR (pseudo-random backpressure). Undefined: tready is never throttled.
// Ports:
//   s_axis_aclk, s_axis_areset - clock, synchronous active-high reset
//   s_axis        - stream slave (tdata/tstrb/tkeep/tvalid/tlast in, tready out)
//   clr           - soft clear of pointer, counters and flags
//   rd_addr/rd_data - read-back port, 1-cycle latency
//   wr_ptr        - next write address
//   pkt_count     - completed packets (wrapping)
//   last_pkt_len  - beats in last completed packet (saturating)
//   pkt_done      - pulse the cycle after a tlast beat is accepted
//   full          - stall state indicator
//   overflow      - sticky, wrap mode wrote past DEPTH-1
//
// state  | meaning
// S_IDLE | no packet open
// S_PKT  | packet in progress (at least one non-last beat accepted)
// S_FULL | stall mode wrote DEPTH-1; tready low until clr/reset
module axis_pkt_sink_mem
  import axis_sink_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 128,
  parameter  int OVF_MODE    = 0,
  parameter  int PKT_RESTART = 1,
  localparam int AW          = $clog2(DEPTH),
  localparam int NB          = DATA_W / 8
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_areset,
  axis_pkt_sink_mem_if.slave   s_axis,
  input  logic                 clr,
  input  logic [AW-1:0]        rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [AW-1:0]        wr_ptr,
  output logic [LEN_W-1:0]     pkt_count,
  output logic [LEN_W-1:0]     last_pkt_len,
  output logic                 pkt_done,
  output logic                 full,
  output logic                 overflow
);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] pkts_q, pkts_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_inc;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             rst_dly_q;
  logic             flow_ok;
  logic             tready;
  logic             accept;
  logic             at_end;

`ifdef AXIS_SINK_FLOW_SIM_EN
  logic [5:0] lfsr_q;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset || clr) lfsr_q <= LFSR_SEED;
    else                      lfsr_q <= lfsr_next(lfsr_q);
  end

  assign flow_ok = lfsr_q[5];
`else
  assign flow_ok = 1'b1;
`endif

  // Delayed reset copy keeps tready low for one cycle after reset release.
  always_ff @(posedge s_axis_aclk) begin
    rst_dly_q <= s_axis_areset;
  end

  assign tready = !s_axis_areset && !rst_dly_q && !clr &&
                  (state_q != S_FULL) && flow_ok;
  assign s_axis.tready = tready;
  assign accept = s_axis.tvalid && tready;
  assign at_end = (ptr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    pkts_d   = pkts_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    beat_inc = (&beat_q) ? beat_q : beat_q + LEN_W'(1);

    if (clr) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      beat_d  = '0;
      pkts_d  = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (s_axis.tlast) begin
        len_d   = beat_inc;
        beat_d  = '0;
        pkts_d  = pkts_q + LEN_W'(1);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        beat_d  = beat_inc;
        state_d = S_PKT;
      end

      // Restart wins over the end-of-memory policy; a stall at DEPTH-1
      // overrides the IDLE/PKT choice above, even on a tlast beat.
      if (s_axis.tlast && PKT_RESTART == 1) begin
        ptr_d = '0;
      end else if (at_end && OVF_MODE == OVF_WRAP) begin
        ptr_d = '0;
        ovf_d = 1'b1;
      end else if (at_end) begin
        state_d = S_FULL;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      pkts_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      pkts_q  <= pkts_d;
      len_q   <= len_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  axis_sink_bytemem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i     (s_axis_aclk),
    .rst_i     (s_axis_areset),
    .we_i      (accept),
    .be_i      (s_axis.tkeep & s_axis.tstrb),
    .wr_addr_i (ptr_q),
    .wr_data_i (s_axis.tdata),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign wr_ptr       = ptr_q;
  assign pkt_count    = pkts_q;
  assign last_pkt_len = len_q;
  assign pkt_done     = done_q;
  assign full         = (state_q == S_FULL);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_axis_pkt_sink_mem.sv
// Bench for axis_pkt_sink_mem: three instances (default, stall DEPTH=8,
// wrap DEPTH=8) share one stimulus driver; sel picks the active one.
module tb_axis_pkt_sink_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0, tstrb = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, clr = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        rd_vld = 1'b0, rd_vld_d = 1'b0;
  int          sel = 0;

  always #5 clk = ~clk;

  logic [2:0]        tready_a, done_a, full_a, ovf_a;
  logic [2:0][31:0]  rd_data_a;
  logic [2:0][15:0]  pc_a, len_a;
  logic [6:0]        wp0;
  logic [2:0]        wp1, wp2;
  logic [2:0][6:0]   wr_ptr_a;
  assign wr_ptr_a = {{4'b0, wp2}, {4'b0, wp1}, wp0};

  axis_pkt_sink_mem_if #(.DATA_W(32)) ax0 ();
  axis_pkt_sink_mem_if #(.DATA_W(32)) ax1 ();
  axis_pkt_sink_mem_if #(.DATA_W(32)) ax2 ();

  assign ax0.tdata = tdata; assign ax0.tkeep = tkeep; assign ax0.tstrb = tstrb;
  assign ax0.tlast = tlast; assign ax0.tvalid = tvalid && (sel == 0);
  assign ax1.tdata = tdata; assign ax1.tkeep = tkeep; assign ax1.tstrb = tstrb;
  assign ax1.tlast = tlast; assign ax1.tvalid = tvalid && (sel == 1);
  assign ax2.tdata = tdata; assign ax2.tkeep = tkeep; assign ax2.tstrb = tstrb;
  assign ax2.tlast = tlast; assign ax2.tvalid = tvalid && (sel == 2);
  assign tready_a = {ax2.tready, ax1.tready, ax0.tready};

  axis_pkt_sink_mem #(.DATA_W(32), .DEPTH(128), .OVF_MODE(0), .PKT_RESTART(1)) dut0 (
    .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis(ax0), .clr(clr && sel == 0),
    .rd_addr(rd_addr), .rd_data(rd_data_a[0]), .wr_ptr(wp0), .pkt_count(pc_a[0]),
    .last_pkt_len(len_a[0]), .pkt_done(done_a[0]), .full(full_a[0]), .overflow(ovf_a[0]));

  axis_pkt_sink_mem #(.DATA_W(32), .DEPTH(8), .OVF_MODE(0), .PKT_RESTART(0)) dut1 (
    .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis(ax1), .clr(clr && sel == 1),
    .rd_addr(rd_addr[2:0]), .rd_data(rd_data_a[1]), .wr_ptr(wp1), .pkt_count(pc_a[1]),
    .last_pkt_len(len_a[1]), .pkt_done(done_a[1]), .full(full_a[1]), .overflow(ovf_a[1]));

  axis_pkt_sink_mem #(.DATA_W(32), .DEPTH(8), .OVF_MODE(1), .PKT_RESTART(0)) dut2 (
    .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis(ax2), .clr(clr && sel == 2),
    .rd_addr(rd_addr[2:0]), .rd_data(rd_data_a[2]), .wr_ptr(wp2), .pkt_count(pc_a[2]),
    .last_pkt_len(len_a[2]), .pkt_done(done_a[2]), .full(full_a[2]), .overflow(ovf_a[2]));

  // Reference model: per-instance memory image and counters.
  int          P_DEPTH [3] = '{128, 8, 8};
  int          P_OVF   [3] = '{0, 0, 1};
  int          P_PR    [3] = '{1, 0, 0};
  logic [31:0] m_mem   [3][128];
  bit          m_wr    [3][128];
  int          m_ptr[3], m_beat[3], m_pkts[3], m_len[3];
  bit          m_ovf[3], m_full[3];

  logic [33:0] done_q[$];
  logic [31:0] rd_exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_ptr[k] = 0; m_beat[k] = 0; m_pkts[k] = 0; m_len[k] = 0;
    m_ovf[k] = 0; m_full[k] = 0;
  endtask

  task automatic model_accept(input logic [31:0] d, input logic [3:0] k,
                              input logic [3:0] s, input logic l);
    for (int i = 0; i < 4; i++)
      if (k[i] && s[i]) m_mem[sel][m_ptr[sel]][8*i +: 8] = d[8*i +: 8];
    m_wr[sel][m_ptr[sel]] = 1'b1;
    if (m_beat[sel] < 65535) m_beat[sel]++;
    if (l) begin
      m_len[sel]  = m_beat[sel];
      m_beat[sel] = 0;
      m_pkts[sel] = (m_pkts[sel] + 1) % 65536;
      done_q.push_back({2'(sel), 16'(m_pkts[sel]), 16'(m_len[sel])});
    end
    if (l && P_PR[sel] == 1) m_ptr[sel] = 0;
    else if (m_ptr[sel] == P_DEPTH[sel] - 1) begin
      if (P_OVF[sel] == 1) begin m_ptr[sel] = 0; m_ovf[sel] = 1; end
      else m_full[sel] = 1;
    end else m_ptr[sel]++;
  endtask

  task automatic try_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                          input logic l, input int maxc, output bit ok);
    tdata = d; tkeep = k; tstrb = s; tlast = l; tvalid = 1'b1; ok = 0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge clk);
      if (tready_a[sel]) ok = 1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    if (ok) model_accept(d, k, s, l);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                           input logic l);
    bit ok;
    try_beat(d, k, s, l, 50, ok);
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: dut %0d never raised tready for data 0x%0h", sel, d);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear(sel);
  endtask

  task automatic read_check(input int a);
    rd_addr = 7'(a); rd_vld = 1'b1;
    rd_exp_q.push_back(m_mem[sel][a]);
    @(posedge clk); #1;
    rd_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_wr_ptr"},    wr_ptr_a[sel], 64'(m_ptr[sel]));
    chk({tag, "_pkt_count"}, pc_a[sel],     64'(m_pkts[sel]));
    chk({tag, "_last_len"},  len_a[sel],    64'(m_len[sel]));
    chk({tag, "_full"},      full_a[sel],   64'(m_full[sel]));
    chk({tag, "_overflow"},  ovf_a[sel],    64'(m_ovf[sel]));
    @(posedge clk); #1;
  endtask

  always @(posedge clk) rd_vld_d <= rd_vld;

  // Monitor: pops expectations whenever the DUT presents pkt_done or read data.
  always @(negedge clk) begin
    logic [33:0] e;
    for (int k = 0; k < 3; k++) begin
      if (done_a[k] === 1'b1) begin
        if (done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pkt_done_unexpected: dut %0d pulsed, got count %0d len %0d, expected none",
                   k, pc_a[k], len_a[k]);
        end else begin
          e = done_q.pop_front();
          chk($sformatf("pkt_done_dut%0d", k), {2'(k), pc_a[k], len_a[k]}, 64'(e));
        end
      end
    end
    if (rd_vld_d) begin
      if (rd_exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_data_unexpected: got 0x%0h, expected no read", rd_data_a[sel]);
      end else chk("rd_data", rd_data_a[sel], 64'(rd_exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len, a, acc, exp_acc;
    logic [5:0]  l6;
    logic [3:0]  kk;
    for (int k = 0; k < 3; k++) model_clear(k);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tready%0d", k),   tready_a[k], 0);
      chk($sformatf("rst_wr_ptr%0d", k),   wr_ptr_a[k], 0);
      chk($sformatf("rst_rd_data%0d", k),  rd_data_a[k], 0);
    end
    chk("rst_pkt_count", pc_a[0], 0);
    chk("rst_last_len",  len_a[0], 0);
    chk("rst_pkt_done",  done_a[0], 0);
    chk("rst_full",      full_a[0], 0);
    chk("rst_overflow",  ovf_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_cycle_after_rst", tready_a[0], 0);
`ifndef AXIS_SINK_FLOW_SIM_EN
    @(negedge clk);
    chk("tready_after_rst_delay", tready_a[0], 1);
`endif
    @(posedge clk); #1;

    // 4-beat packet into the default instance
    sel = 0;
    for (int b = 0; b < 4; b++)
      send_beat(32'h1111_1111 * (b + 1), 4'hF, 4'hF, b == 3);
    check_state("pkt4");
    chk("pkt4_count_const", pc_a[0], 1);
    chk("pkt4_len_const",   len_a[0], 4);
    for (int b = 0; b < 4; b++) read_check(b);

    // Byte mask over a zeroed word
    send_beat(32'h0, 4'hF, 4'hF, 1'b1);
    send_beat(32'hAABB_CCDD, 4'hF, 4'b0101, 1'b1);
    read_check(0);
    check_state("mask");

    // Randomised packets with random keep/strb
    for (int p = 0; p < 15; p++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        kk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        send_beat($urandom, kk, 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1) * 15),
                  b == len - 1);
      end
      check_state("rand");
      a = $urandom_range(0, 5);
      if (m_wr[0][a]) read_check(a);
    end

    // Reset mid-packet, then a fresh 2-beat packet
    for (int b = 0; b < 3; b++) send_beat(32'hDEAD_0000 + b, 4'hF, 4'hF, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_clear(k);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_beat(32'hCAFE_0001, 4'hF, 4'hF, 1'b0);
    send_beat(32'hCAFE_0002, 4'hF, 4'hF, 1'b1);
    check_state("midrst");
    chk("midrst_len_const",   len_a[0], 2);
    chk("midrst_count_const", pc_a[0], 1);

    // Stall mode, DEPTH=8: 8 beats fill memory, beat 9 held until clr
    sel = 1;
    begin
      bit ok;
      for (int b = 1; b <= 8; b++) send_beat(32'h100 + b, 4'hF, 4'hF, 1'b0);
      check_state("stall_full");
      @(negedge clk);
      chk("stall_tready_low", tready_a[1], 0);
      @(posedge clk); #1;
      try_beat(32'h109, 4'hF, 4'hF, 1'b0, 6, ok);
      chk("stall_beat9_held", ok, 0);
      pulse_clr();
      check_state("stall_clr");
      send_beat(32'h109, 4'hF, 4'hF, 1'b0);
      send_beat(32'h10A, 4'hF, 4'hF, 1'b0);
      check_state("stall_resume");
      read_check(0); read_check(1); read_check(7);
    end

    // Wrap mode, DEPTH=8: 10 beats, tlast on 10
    sel = 2;
    for (int b = 1; b <= 10; b++) send_beat(32'h200 + b, 4'hF, 4'hF, b == 10);
    check_state("wrap");
    chk("wrap_ptr_const", wr_ptr_a[2], 2);
    chk("wrap_ovf_const", ovf_a[2], 1);
    read_check(0); read_check(1); read_check(2);

    // Flow test: tvalid held for 64 cycles after clr
    sel = 0;
    pulse_clr();
    check_state("flow_clr");
    exp_acc = 64;
`ifdef AXIS_SINK_FLOW_SIM_EN
    l6 = 6'b000101;
    exp_acc = 0;
    for (int c = 0; c < 64; c++) begin
      if (l6[5]) exp_acc++;
      l6 = {l6[4:0], ~(l6[5] ^ l6[4])};
    end
`endif
    acc = 0;
    tkeep = 4'hF; tstrb = 4'hF; tlast = 1'b0; tdata = $urandom; tvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (tready_a[0]) begin
        acc++;
        model_accept(tdata, tkeep, tstrb, tlast);
      end
      @(posedge clk); #1;
      tdata = $urandom;
    end
    tvalid = 1'b0;
    chk("flow_accept_count", 64'(acc), 64'(exp_acc));
    check_state("flow");
    chk("flow_wr_ptr_vs_ref", wr_ptr_a[0], 64'(exp_acc % 128));
    read_check(0);
    read_check(5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pkt_done_all_seen", done_q.size(), 0);
    chk("reads_all_seen",    rd_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
